// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a DIGITS-wide common-strobe 7-segment display.
// One hex nibble per digit is decoded, and the digits are scanned round-robin.
// Each digit holds its slot for PRESCALE clk cycles. New display words arrive
// on a valid/ready port and are double-buffered: a word waits in the pending
// register and is copied to the active register only at a frame boundary.
// A frame never mixes two words.
//
// Optional feature (compile-time macro):
//   SEG7_LZB_EN  leading-zero blanking. Digits above the most significant
//                nonzero nibble of the active word are dark. Digit 0 is never
//                suppressed. This applies in addition to load_blank.
//
// Parameters:
//   DIGITS          number of digits scanned (>=1); digit 0 = least significant nibble
//   PRESCALE        clk cycles per digit slot (>=2)
//   SEG_ACTIVE_LOW  1: seg outputs inverted (lit segment = 0)
//   DIG_ACTIVE_LOW  1: dig outputs inverted (selected digit = 0)
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous assert, synchronous release, active low
//   load_valid  in   load_data/load_blank present
//   load_ready  out  pending buffer empty; a word is accepted on valid && ready
//   load_data   in   4*DIGITS bits, nibble i -> digit i
//   load_blank  in   DIGITS bits, 1 = force digit i dark
//   enable      in   0 = seg/dig inactive (scan timing keeps running)
//   seg         out  {a,b,c,d,e,f,g}, registered
//   dig         out  one-hot digit strobe, registered
//   frame_done  out  1-cycle pulse in the frame-boundary cycle
// ----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned PRESCALE       = 1000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     load_blank,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_done
);

    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // Inactive output levels. These are also the reset values.
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic [PS_W-1:0]  prescaler;
    logic [IDX_W-1:0] index;
    logic             tc;
    logic             boundary;

    assign tc         = (prescaler == PS_LAST);
    assign boundary   = tc && (index == IDX_LAST);
    assign frame_done = boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            index     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. Every
            // flop then samples pre-edge values, whatever order the blocks run in.
            if (tc) begin
                prescaler <= '0;
                index     <= (index == IDX_LAST) ? '0 : index + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: the load port writes pending. Pending moves to active
    // only at a frame boundary. An accept needs an empty pending register,
    // and a transfer needs a full one, so the two never collide. A word
    // accepted in the boundary cycle waits for the next boundary.
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] active_data;
    logic [DIGITS-1:0]   active_blank;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_blank;
    logic                pend_full;

    assign load_ready = ~pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are a few plain registers, not a memory array, so a
            // reset costs nothing. Clearing them also makes a mid-frame reset
            // discard stale words.
            active_data  <= '0;
            active_blank <= '1;
            pend_data    <= '0;
            pend_blank   <= '0;
            pend_full    <= 1'b0;
        end else begin
            if (boundary && pend_full) begin
                active_data  <= pend_data;
                active_blank <= pend_blank;
                pend_full    <= 1'b0;
            end else if (load_valid && !pend_full) begin
                pend_data    <= load_data;
                pend_blank   <= load_blank;
                pend_full    <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression mask
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] lz_dark;

`ifdef SEG7_LZB_EN
    always_comb begin
        logic upper_zero;
        lz_dark    = '0;
        upper_zero = 1'b1;
        // Walk down from the top digit. A digit is dark while it and every
        // digit above it hold zero. Digit 0 always shows.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (active_data[i*4 +: 4] == 4'h0);
            lz_dark[i] = upper_zero && (i != 0);
        end
    end
`else
    assign lz_dark = '0;
`endif

    // ------------------------------------------------------------------
    // Current-slot selection and decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'h7E;
            4'h1: hex_decode = 7'h30;
            4'h2: hex_decode = 7'h6D;
            4'h3: hex_decode = 7'h79;
            4'h4: hex_decode = 7'h33;
            4'h5: hex_decode = 7'h5B;
            4'h6: hex_decode = 7'h5F;
            4'h7: hex_decode = 7'h70;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h7B;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h1F;
            4'hC: hex_decode = 7'h4E;
            4'hD: hex_decode = 7'h3D;
            4'hE: hex_decode = 7'h4F;
            4'hF: hex_decode = 7'h47;
        endcase
    endfunction

    logic [3:0]        cur_nibble;
    logic              cur_dark;
    logic [DIGITS-1:0] dig_onehot;

    always_comb begin
        // NOTE: every signal gets a default before the loop. Without it, any
        // path that skips an assignment would infer a latch.
        cur_nibble = 4'h0;
        cur_dark   = 1'b0;
        dig_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (index == IDX_W'(i)) begin
                cur_nibble    = active_data[i*4 +: 4];
                cur_dark      = active_blank[i] || lz_dark[i];
                dig_onehot[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers. Polarity is applied here, so the pins come straight
    // from flops and reset lands on the inactive level.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dig <= DIG_OFF;
        end else if (!enable) begin
            seg <= SEG_OFF;
            dig <= DIG_OFF;
        end else begin
            seg <= (cur_dark ? 7'h00 : hex_decode(cur_nibble)) ^ SEG_OFF;
            dig <= dig_onehot ^ DIG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Bench for seg7_scan_driver with DIGITS=4 and PRESCALE=4. It instantiates the
// design twice: once with active-high outputs and once with both outputs
// active low. Both copies share all inputs.
//
// The reference model describes the display in terms of elapsed cycles since
// reset. The slot index is (t / PRESCALE) % DIGITS, and a frame boundary is
// the last cycle of every DIGITS*PRESCALE-cycle frame. Loaded words move
// through a pending -> active pair. A compare process checks every output of
// both copies on each falling edge. Directed scenarios add literal, hand-
// computed expectations that pin the model to the decode table.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int P     = 4;
    localparam int D     = 4;
    localparam int FRAME = P * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic [3:0]  load_blank = 4'h0;
    logic        enable = 1'b0;

    logic        load_ready, frame_done;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic        load_ready_n, frame_done_n;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(D), .PRESCALE(P), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_blank(load_blank), .enable(enable),
        .seg(seg), .dig(dig), .frame_done(frame_done)
    );

    seg7_scan_driver #(.DIGITS(D), .PRESCALE(P), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_n (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_n),
        .load_data(load_data), .load_blank(load_blank), .enable(enable),
        .seg(seg_n), .dig(dig_n), .frame_done(frame_done_n)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [6:0] dec_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int          t;
    logic [15:0] m_data, m_pdata;
    logic [3:0]  m_blank, m_pblank;
    logic        m_pfull;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;

    function automatic logic [6:0] model_seg(input int tt, input logic [15:0] data,
                                             input logic [3:0] blank, input logic en);
        int  idx;
        bit  dark;
        idx  = (tt / P) % D;
        dark = blank[idx];
`ifdef SEG7_LZB_EN
        if (idx != 0 && (data >> (4 * idx)) == 16'h0) dark = 1'b1;
`endif
        if (!en || dark) return 7'h00;
        return dec_tab[(data >> (4 * idx)) & 16'hF];
    endfunction

    function automatic logic [3:0] model_dig(input int tt, input logic en);
        if (!en) return 4'h0;
        return 4'(1 << ((tt / P) % D));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t        <= 0;
            m_data   <= 16'h0;
            m_blank  <= 4'hF;
            m_pdata  <= 16'h0;
            m_pblank <= 4'h0;
            m_pfull  <= 1'b0;
            exp_seg  <= 7'h00;
            exp_dig  <= 4'h0;
        end else begin
            t       <= t + 1;
            exp_seg <= model_seg(t, m_data, m_blank, enable);
            exp_dig <= model_dig(t, enable);
            if ((t % FRAME) == FRAME - 1 && m_pfull) begin
                m_data  <= m_pdata;
                m_blank <= m_pblank;
                m_pfull <= 1'b0;
            end else if (load_valid && !m_pfull) begin
                m_pdata  <= load_data;
                m_pblank <= load_blank;
                m_pfull  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event did not occur within its cycle budget (time %0t)", name, $time);
    endtask

    always @(negedge clk) begin
        check("seg",          seg, exp_seg);
        check("dig",          dig, exp_dig);
        check("seg_low",      seg_n ^ 7'h7F, exp_seg);
        check("dig_low",      dig_n ^ 4'hF, exp_dig);
        check("load_ready",   load_ready, !m_pfull);
        check("load_ready_n", load_ready_n, !m_pfull);
        check("frame_done",   frame_done, rst_n && (t % FRAME) == FRAME - 1);
        check("frame_done_n", frame_done_n, rst_n && (t % FRAME) == FRAME - 1);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Hold valid until the handshake completes. Returns #1 after the
    // accepting edge.
    task automatic do_load(input logic [15:0] d, input logic [3:0] b);
        logic ok;
        bit   done;
        done       = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        load_blank = b;
        for (int i = 0; i < 4 * FRAME && !done; i++) begin
            ok = load_ready;
            @(posedge clk);
            #1;
            if (ok) done = 1'b1;
        end
        load_valid = 1'b0;
        if (!done) timeout("load_handshake");
    endtask

    // Returns on the falling edge inside the frame-boundary cycle.
    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME + 4 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) timeout("frame_done_wait");
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Reset asserted mid-slot while a digit strobe is active. The outputs
        // must go idle without waiting for a clock edge.
        repeat (6) @(negedge clk);
        check("pre_reset_dig", dig, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg",   seg, 7'h00);
        check("async_rst_dig",   dig, 4'b0000);
        check("async_rst_ready", load_ready, 1'b1);
        check("async_rst_fd",    frame_done, 1'b0);
        check("async_rst_seg_n", seg_n, 7'h7F);
        check("async_rst_dig_n", dig_n, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;

        // 12AF shows F/A/2/1 across the four slots of the next frame.
        do_load(16'h12AF, 4'h0);
        check("ready_after_accept", load_ready, 1'b0);
        wait_frame();
        repeat (2) @(negedge clk);
        check("d0_dig", dig, 4'b0001); check("d0_seg", seg, 7'h47);
        repeat (4) @(negedge clk);
        check("d1_dig", dig, 4'b0010); check("d1_seg", seg, 7'h77);
        repeat (4) @(negedge clk);
        check("d2_dig", dig, 4'b0100); check("d2_seg", seg, 7'h6D);
        repeat (4) @(negedge clk);
        check("d3_dig", dig, 4'b1000); check("d3_seg", seg, 7'h30);
        repeat (2) @(negedge clk);
        check("fd_16_cycles", frame_done, 1'b1);

        // Back-to-back loads. The second word is held off until the boundary.
        do_load(16'h1111, 4'h0);
        check("ready_low_full", load_ready, 1'b0);
        do_load(16'h2222, 4'h0);
        check("first_word_shown", seg, 7'h30);
        wait_frame();
        repeat (2) @(negedge clk);
        check("second_word_shown", seg, 7'h6D);

        // Blank digit 2. Its strobe still fires, but its segments stay dark.
        do_load(16'h8888, 4'b0100);
        wait_frame();
        repeat (10) @(negedge clk);
        check("blank_dig", dig, 4'b0100); check("blank_seg", seg, 7'h00);
        repeat (4) @(negedge clk);
        check("unblank_dig", dig, 4'b1000); check("unblank_seg", seg, 7'h7F);

        // Leading zeros in 0050.
        do_load(16'h0050, 4'h0);
        wait_frame();
        repeat (2) @(negedge clk);
        check("lz_d0", seg, 7'h7E);
        repeat (4) @(negedge clk);
        check("lz_d1", seg, 7'h5B);
        repeat (4) @(negedge clk);
`ifdef SEG7_LZB_EN
        check("lz_d2", seg, 7'h00);
`else
        check("lz_d2", seg, 7'h7E);
`endif
        repeat (4) @(negedge clk);
`ifdef SEG7_LZB_EN
        check("lz_d3", seg, 7'h00);
`else
        check("lz_d3", seg, 7'h7E);
`endif

        // Disable during digit 1's slot. Outputs go idle the next clk while
        // frame timing keeps running.
        wait_frame();
        repeat (6) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_seg",   seg, 7'h00);
        check("dis_dig",   dig, 4'b0000);
        check("dis_seg_n", seg_n, 7'h7F);
        check("dis_dig_n", dig_n, 4'b1111);
        repeat (9) @(negedge clk);
        check("dis_fd", frame_done, 1'b1);
        repeat (16) @(negedge clk);
        check("dis_fd_next", frame_done, 1'b1);
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
